// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, refill FSM states and index helper for the I-cache data array
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } fill_state_e;

  function automatic int off_bits(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int beats_of(input int line_w, input int beat_w);
    return line_w / beat_w;
  endfunction

  function automatic int cnt_bits(input int line_w, input int beat_w);
    return $clog2(line_w / beat_w);
  endfunction

  // Set index of a byte address: the bits just above the line offset.
  function automatic logic [31:0] index_of(input logic [63:0] addr, input int off_b,
                                           input int idx_b);
    logic [63:0] mask;
    mask = (64'd1 << idx_b) - 64'd1;
    return 32'((addr >> off_b) & mask);
  endfunction

endpackage

// File: rtl/icache_way_ram.sv
// rtl/icache_way_ram.sv - one way of line storage: write port A, registered read port B
module icache_way_ram #(
  parameter int SETS   = 64,
  parameter int LINE_W = 512,
  parameter int IDX_B  = 6
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              we_a_i,
  input  logic [IDX_B-1:0]  waddr_a_i,
  input  logic [LINE_W-1:0] wdata_a_i,
  input  logic              re_b_i,
  input  logic [IDX_B-1:0]  raddr_b_i,
  output logic [LINE_W-1:0] rdata_b_o
);

  logic [LINE_W-1:0] mem_q [SETS];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_a_i) begin
      mem_q[waddr_a_i] <= wdata_a_i;
    end
  end

  // Read returns the pre-write contents on a same-cycle collision; the top forwards.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdata_q <= '0;
    end else if (re_b_i) begin
      rdata_q <= mem_q[raddr_b_i];
    end
  end

  assign rdata_b_o = rdata_q;

endmodule

// File: rtl/icache_data_array.sv
// rtl/icache_data_array.sv - N-way I-cache data store with beat-wise refill assembler
module icache_data_array
  import cache_pkg::*;
#(
  parameter int WAYS   = 4,
  parameter int SETS   = 64,
  parameter int LINE_W = 512,
  parameter int BEAT_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic                   rd_valid,
  output logic [WAYS*LINE_W-1:0] rd_data,
  input  logic                   fill_start,
  input  logic [ADDR_W-1:0]      fill_addr,
  input  logic [WAYS-1:0]        fill_way,
  output logic                   fill_busy,
  input  logic                   fill_beat_valid,
  input  logic [BEAT_W-1:0]      fill_beat_data,
  output logic                   fill_beat_ready,
  output logic                   fill_done
);

  localparam int OFF_B = off_bits(LINE_W);
  localparam int IDX_B = idx_bits(SETS);
  localparam int BEATS = beats_of(LINE_W, BEAT_W);
  localparam int CNT_B = cnt_bits(LINE_W, BEAT_W);

  fill_state_e       state_q;
  logic [IDX_B-1:0]  fill_idx_q;
  logic [WAYS-1:0]   fill_way_q;
  logic [CNT_B-1:0]  cnt_q;
  logic              busy_q;
  logic              ready_q;
  logic              done_q;
  logic [LINE_W-1:0] buf_q;
  logic              rd_valid_q;
  logic [WAYS-1:0]   fwd_d;
  logic [WAYS-1:0]   fwd_q;
  logic [LINE_W-1:0] fwd_line_q;

  logic [IDX_B-1:0]       rd_idx;
  logic [IDX_B-1:0]       fill_idx;
  logic                   beat_acc;
  logic                   commit;
  logic [BEATS-1:0]       beat_en;
  logic [WAYS-1:0]        way_we;
  logic [WAYS*LINE_W-1:0] ram_rdata;

  assign rd_idx   = IDX_B'(index_of(64'(rd_addr), OFF_B, IDX_B));
  assign fill_idx = IDX_B'(index_of(64'(fill_addr), OFF_B, IDX_B));
  assign beat_acc = fill_beat_valid && ready_q;
  assign commit   = (state_q == COMMIT);
  assign way_we   = commit ? fill_way_q : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      fill_idx_q <= '0;
      fill_way_q <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fill_start) begin
            state_q    <= FILL;
            fill_idx_q <= fill_idx;
            fill_way_q <= fill_way;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            ready_q    <= 1'b1;
          end
        end
        FILL: begin
          if (beat_acc) begin
            cnt_q <= cnt_q + CNT_B'(1);
            if (cnt_q == CNT_B'(BEATS - 1)) begin
              state_q <= COMMIT;
              ready_q <= 1'b0;
            end
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    beat_en = '0;
    if (beat_acc) begin
      beat_en[cnt_q] = 1'b1;
    end
  end

  // Contents are only meaningful once all beats land, so the buffer needs no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < BEATS; k++) begin
      if (beat_en[k]) begin
        buf_q[k*BEAT_W +: BEAT_W] <= fill_beat_data;
      end
    end
  end

  always_comb begin
    fwd_d = '0;
    if (commit && (rd_idx == fill_idx_q)) begin
      fwd_d = fill_way_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid_q <= 1'b0;
      fwd_q      <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        fwd_q <= fwd_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en && (|fwd_d)) begin
      fwd_line_q <= buf_q;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way_ram #(
      .SETS   (SETS),
      .LINE_W (LINE_W),
      .IDX_B  (IDX_B)
    ) u_ram (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .we_a_i    (way_we[w]),
      .waddr_a_i (fill_idx_q),
      .wdata_a_i (buf_q),
      .re_b_i    (rd_en),
      .raddr_b_i (rd_idx),
      .rdata_b_o (ram_rdata[w*LINE_W +: LINE_W])
    );

    assign rd_data[w*LINE_W +: LINE_W] = fwd_q[w] ? fwd_line_q : ram_rdata[w*LINE_W +: LINE_W];
  end

  assign rd_valid        = rd_valid_q;
  assign fill_busy       = busy_q;
  assign fill_beat_ready = ready_q;
  assign fill_done       = done_q;

endmodule

// File: tb/tb_icache_data_array.sv
// tb/tb_icache_data_array.sv - scoreboard bench for icache_data_array against a line-level model
module tb_icache_data_array;

  localparam int WAYS   = 4;
  localparam int SETS   = 64;
  localparam int LINE_W = 512;
  localparam int BEAT_W = 32;
  localparam int ADDR_W = 32;
  localparam int BEATS  = LINE_W / BEAT_W;

  typedef logic [LINE_W-1:0] line_t;
  typedef struct {
    logic [WAYS*LINE_W-1:0] data;
    logic [WAYS-1:0]        known;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   rd_en = 1'b0;
  logic [ADDR_W-1:0]      rd_addr = '0;
  logic                   rd_valid;
  logic [WAYS*LINE_W-1:0] rd_data;
  logic                   fill_start = 1'b0;
  logic [ADDR_W-1:0]      fill_addr = '0;
  logic [WAYS-1:0]        fill_way = '0;
  logic                   fill_busy;
  logic                   fill_beat_valid = 1'b0;
  logic [BEAT_W-1:0]      fill_beat_data = '0;
  logic                   fill_beat_ready;
  logic                   fill_done;

  int    n_checks = 0;
  int    n_fail = 0;
  line_t model_mem   [WAYS][SETS];
  bit    model_known [WAYS][SETS];
  exp_t  sb_q[$];
  exp_t  last_exp;

  icache_data_array #(
    .WAYS(WAYS), .SETS(SETS), .LINE_W(LINE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rstn(rstn), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .fill_start(fill_start), .fill_addr(fill_addr), .fill_way(fill_way),
    .fill_busy(fill_busy), .fill_beat_valid(fill_beat_valid), .fill_beat_data(fill_beat_data),
    .fill_beat_ready(fill_beat_ready), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd64) % SETS);
  endfunction

  function automatic exp_t model_read(input int idx);
    exp_t e;
    for (int w = 0; w < WAYS; w++) begin
      e.data[w*LINE_W +: LINE_W] = model_mem[w][idx];
      e.known[w] = model_known[w][idx];
    end
    return e;
  endfunction

  function automatic void model_write(input int idx, input logic [WAYS-1:0] way, input line_t l);
    for (int w = 0; w < WAYS; w++) begin
      if (way[w]) begin
        model_mem[w][idx] = l;
        model_known[w][idx] = 1'b1;
      end
    end
  endfunction

  function automatic line_t rand_line();
    line_t l;
    for (int k = 0; k < BEATS; k++) l[k*BEAT_W +: BEAT_W] = $urandom;
    return l;
  endfunction

  function automatic line_t seq_line(input logic [31:0] base);
    line_t l;
    for (int k = 0; k < BEATS; k++) l[k*BEAT_W +: BEAT_W] = base + k;
    return l;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input line_t act, input line_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_exp(input string name, input exp_t e);
    for (int w = 0; w < WAYS; w++) begin
      if (e.known[w]) begin
        chk_line($sformatf("%s_way%0d", name, w), rd_data[w*LINE_W +: LINE_W],
                 e.data[w*LINE_W +: LINE_W]);
      end
    end
  endtask

  // Monitor: one cycle after each issued read the response must appear; otherwise data holds.
  initial begin
    exp_t e;
    last_exp.data  = '0;
    last_exp.known = '1;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        sb_q.delete();
        last_exp.data  = '0;
        last_exp.known = '1;
      end else begin
        chk("rd_valid", rd_valid, sb_q.size() > 0);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          if (rd_valid) begin
            last_exp = e;
            cmp_exp("rd_data", e);
          end
        end else if (!rd_valid) begin
          cmp_exp("rd_hold", last_exp);
        end
      end
    end
  end

  task automatic do_read(input logic [31:0] a);
    @(negedge clk);
    rd_en = 1'b1;
    rd_addr = a;
    sb_q.push_back(model_read(idx_of(a)));
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic rand_reads(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd_en = ($urandom_range(0, 3) != 0);
      rd_addr = ($urandom << 12) | (32'($urandom_range(0, 15)) << 6) | 32'($urandom_range(0, 63));
      if (rd_en) sb_q.push_back(model_read(idx_of(rd_addr)));
    end
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_fill(input logic [31:0] addr, input logic [WAYS-1:0] way, input line_t line,
                         input bit gaps, input bit collide, input bit mid_start,
                         input int abort_after, input bit started, input bit chain,
                         input logic [31:0] chain_addr, input logic [WAYS-1:0] chain_way);
    int k;
    int cyc;
    bit v;
    if (!started) begin
      @(negedge clk);
      fill_start = 1'b1;
      fill_addr = addr;
      fill_way = way;
      @(negedge clk);
      fill_start = 1'b0;
    end
    chk("fill_busy_entry", fill_busy, 1);
    k = 0;
    cyc = 0;
    while (k < BEATS) begin
      if (abort_after == k) begin
        fill_beat_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("abort_busy", fill_busy, 0);
        chk("abort_ready", fill_beat_ready, 0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("abort_no_done", fill_done, 0);
        end
        return;
      end
      v = !gaps || (cyc % 2 == 1);
      chk("ready_in_fill", fill_beat_ready, 1);
      fill_beat_valid = v;
      fill_beat_data = line[k*BEAT_W +: BEAT_W];
      fill_start = mid_start && (k == 5);
      fill_addr = fill_start ? 32'h0 : addr;
      fill_way = fill_start ? 4'b0001 : way;
      @(negedge clk);
      if (v) k++;
      cyc++;
    end
    fill_beat_valid = 1'b0;
    fill_start = 1'b0;
    fill_addr = addr;
    fill_way = way;
    chk("commit_busy", fill_busy, 1);
    chk("commit_ready", fill_beat_ready, 0);
    chk("commit_no_done", fill_done, 0);
    chk("fill_cycles", gaps ? (cyc >= 2 * BEATS) : (cyc == BEATS), 1);
    model_write(idx_of(addr), way, line);
    if (collide) begin
      rd_en = 1'b1;
      rd_addr = addr;
      sb_q.push_back(model_read(idx_of(addr)));
    end
    @(negedge clk);
    rd_en = 1'b0;
    chk("done_pulse", fill_done, 1);
    chk("done_busy", fill_busy, 0);
    chk("done_ready", fill_beat_ready, 0);
    if (chain) begin
      fill_start = 1'b1;
      fill_addr = chain_addr;
      fill_way = chain_way;
    end
    @(negedge clk);
    fill_start = 1'b0;
    chk("done_single", fill_done, 0);
    chk("busy_after_done", fill_busy, chain);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [WAYS-1:0] wy;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data_zero", rd_data == '0, 1);
    chk("rst_busy", fill_busy, 0);
    chk("rst_ready", fill_beat_ready, 0);
    chk("rst_done", fill_done, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_busy", fill_busy, 0);
    chk("idle_ready", fill_beat_ready, 0);
    do_read(32'h40);

    for (int w = 0; w < WAYS; w++) begin
      do_fill(32'h1C0, WAYS'(1 << w), rand_line(), 0, 0, 0, -1, 0, 0, 0, 0);
      do_fill(32'h000, WAYS'(1 << w), rand_line(), 1, 0, 0, -1, 0, 0, 0, 0);
    end
    do_read(32'h1C0);
    do_read(32'h000);

    do_fill(32'h1C0, 4'b0100, seq_line(32'h1000), 0, 0, 0, -1, 0, 0, 0, 0);
    do_read(32'h1C0);

    do_fill(32'h1C0, 4'b0100, rand_line(), 0, 0, 0, -1, 0, 0, 0, 0);
    do_fill(32'h1C0, 4'b0100, seq_line(32'h1000), 1, 0, 0, -1, 0, 0, 0, 0);
    do_read(32'h1C0);

    do_fill(32'h1C0, 4'b0100, rand_line(), 0, 1, 0, -1, 0, 0, 0, 0);
    do_read(32'h1C0);

    do_fill(32'h1C0, 4'b0100, rand_line(), 0, 0, 1, -1, 0, 0, 0, 0);
    do_read(32'h000);
    do_read(32'h1C0);

    do_fill(32'h1C0, 4'b0010, rand_line(), 0, 0, 0, -1, 0, 1, 32'h80, 4'b0001);
    do_fill(32'h80, 4'b0001, rand_line(), 0, 0, 0, -1, 1, 0, 0, 0);
    do_read(32'h1C0);
    do_read(32'h80);

    do_fill(32'h1C0, 4'b0100, rand_line(), 0, 0, 0, 8, 0, 0, 0, 0);
    do_read(32'h1C0);

    for (int i = 0; i < 8; i++) begin
      a = ($urandom << 12) | (32'($urandom_range(0, 15)) << 6);
      wy = WAYS'(1 << $urandom_range(0, WAYS - 1));
      do_fill(a, wy, rand_line(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, -1,
              0, 0, 0, 0);
      rand_reads(12);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
